// File: rtl/fifo_read_ctrl.sv
// Read-side burst master for the sync FIFO: pops burst_len words and
// streams them downstream through a 2-entry skid buffer that hides the
// FIFO's one-cycle read latency.
module fifo_read_ctrl #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned LEN_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_W-1:0]      burst_len,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            err_cnt
);

  localparam int unsigned CW = LEN_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state, next_state;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      issued;
  logic [LEN_W-1:0]      delivered;
  logic                  inflight;
  logic [1:0]            occ;
  logic [FIFO_WIDTH-1:0] tail_q;
  logic                  pop;
  logic                  push;
  logic                  start_acc;
  logic [2:0]            credit_used;

  assign pop       = m_valid && m_ready;
  assign push      = inflight;
  assign start_acc = (state == S_IDLE) && start;
  // Buffer slots spoken for next cycle: held words plus the word in flight,
  // minus the word leaving now. Keeps 1 word/clk while never overflowing.
  assign credit_used = 3'(occ) + 3'(inflight) - 3'(pop);

  // Next-state and read-enable decode
  always_comb begin
    next_state = state;
    fifo_rd_en = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) next_state = (burst_len == '0) ? S_DONE : S_READ;
      end
      S_READ: begin
        if (issued == len_q) next_state = S_DRAIN;
        fifo_rd_en = !fifo_empty && (issued < len_q) && (credit_used < 3'd2);
      end
      S_DRAIN: begin
        if (CW'(delivered) + CW'(pop) == CW'(len_q)) next_state = S_DONE;
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
    if (!rst_n) fifo_rd_en = 1'b0;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Registered status flags derived from the upcoming state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (next_state != S_IDLE);
      done <= (next_state == S_DONE);
    end
  end

  // Burst bookkeeping: length, issued reads, delivered words, read in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q     <= '0;
      issued    <= '0;
      delivered <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      if (start_acc) begin
        len_q     <= burst_len;
        issued    <= '0;
        delivered <= '0;
      end else begin
        if (fifo_rd_en) issued    <= issued + LEN_W'(1);
        if (pop)        delivered <= delivered + LEN_W'(1);
      end
    end
  end

  // 2-entry output buffer; m_data is the head, tail_q the second entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ     <= 2'd0;
      m_valid <= 1'b0;
      m_data  <= '0;
      tail_q  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) m_data <= fifo_data_out;
          else             tail_q <= fifo_data_out;
          occ     <= occ + 2'd1;
          m_valid <= 1'b1;
        end
        2'b01: begin
          m_data  <= tail_q;
          occ     <= occ - 2'd1;
          m_valid <= (occ == 2'd2);
        end
        2'b11: begin
          if (occ == 2'd1) begin
            m_data <= fifo_data_out;
          end else begin
            m_data <= tail_q;
            tail_q <= fifo_data_out;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Saturating count of FIFO underflow pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt <= 8'd0;
    end else if (fifo_underflow && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule
